// File: rtl/shift_exchange_sequencer_pkg.sv
// Shared encodings for the shift-exchange sequencer: shift-register control codes
// and the word-exchange FSM states.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    CTRL_HOLD  = 2'b00,
    CTRL_LEFT  = 2'b01,
    CTRL_RIGHT = 2'b10,
    CTRL_LOAD  = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_exchange_sequencer_usr_core.sv
// N-bit universal shift register: hold, shift left, shift right or parallel load,
// selected per cycle by ctrl.
module usr_core
  import shift_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  ctrl_e        ctrl,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Left shift pulls the new LSB from d[0]; right shift pulls the new MSB from d[N-1].
  always_comb begin
    q_d = q_q;
    case (ctrl)
      CTRL_HOLD:  q_d = q_q;
      CTRL_LEFT:  q_d = {q_q[N-2:0], d[0]};
      CTRL_RIGHT: q_d = {d[N-1], q_q[N-1:1]};
      CTRL_LOAD:  q_d = d;
      default:    q_d = q_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_exchange_sequencer.sv
// Runs full-duplex serial word exchanges: accepts a parallel word, shifts it out
// MSB- or LSB-first while shifting the link data in, then holds the received word.
module shift_exchange_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N       = 8,
  parameter int CLK_DIV = 1,
  parameter int CNT_W   = $clog2(N+1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_dir,
  output logic         ser_out,
  input  logic         ser_in,
  output logic         ser_strobe,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bit_q, bit_d;

  ctrl_e            core_ctrl;
  logic [N-1:0]     core_d;
  logic [N-1:0]     core_q;
  logic             strobe;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    div_d     = div_q;
    bit_d     = bit_q;
    core_ctrl = CTRL_HOLD;
    core_d    = {N{ser_in}};
    strobe    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          core_ctrl = CTRL_LOAD;
          core_d    = in_data;
          dir_d     = in_dir;
          div_d     = '0;
          bit_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The shift edge closes each bit period; ser_in is captured on that edge.
        if (div_q == DIV_LAST) begin
          strobe    = 1'b1;
          core_ctrl = dir_q ? CTRL_RIGHT : CTRL_LEFT;
          div_d     = '0;
          bit_d     = bit_q + CNT_W'(1);
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
    end
  end

  usr_core #(
    .N (N)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .ctrl  (core_ctrl),
    .d     (core_d),
    .q     (core_q)
  );

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_data   = core_q;
  assign ser_strobe = strobe;
  assign ser_out    = (state_q == SHIFT) ? (dir_q ? core_q[0] : core_q[N-1]) : 1'b0;

endmodule

// File: tb/tb_shift_exchange_sequencer.sv
// Bench for shift_exchange_sequencer: two instances (CLK_DIV 1 and 3) share stimulus;
// a bit-order model predicts serial output, strobe timing and the received word.
module tb_shift_exchange_sequencer;
  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_dir = 1'b0;
  logic         ser_in = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] in_data = '0;

  logic         in_ready1, ser_out1, ser_strobe1, busy1, out_valid1;
  logic [N-1:0] out_data1;
  logic         in_ready3, ser_out3, ser_strobe3, busy3, out_valid3;
  logic [N-1:0] out_data3;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  shift_exchange_sequencer #(.N(N), .CLK_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_dir(in_dir), .ser_out(ser_out1), .ser_in(ser_in),
    .ser_strobe(ser_strobe1), .busy(busy1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1)
  );

  shift_exchange_sequencer #(.N(N), .CLK_DIV(3)) dut3 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_dir(in_dir), .ser_out(ser_out3), .ser_in(ser_in),
    .ser_strobe(ser_strobe3), .busy(busy3), .out_valid(out_valid3),
    .out_ready(out_ready), .out_data(out_data3)
  );

  // Transmit order: bit k of the word on the wire is data[N-1-k] MSB-first, data[k] LSB-first.
  function automatic logic tx_bit(input logic [N-1:0] data, input logic dir, input int k);
    return dir ? data[k] : data[N-1-k];
  endfunction

  // Received word: first wire bit lands in the MSB (dir 0) or the LSB (dir 1).
  function automatic logic [N-1:0] rx_word(input logic [N-1:0] wire_bits, input logic dir);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (dir) r[i] = wire_bits[i];
      else     r[N-1-i] = wire_bits[i];
    end
    return r;
  endfunction

  task automatic sample(input int div, output logic ir, output logic so, output logic ss,
                        output logic bz, output logic ov, output logic [N-1:0] od);
    if (div == 3) begin
      ir = in_ready3; so = ser_out3; ss = ser_strobe3; bz = busy3; ov = out_valid3; od = out_data3;
    end else begin
      ir = in_ready1; so = ser_out1; ss = ser_strobe1; bz = busy1; ov = out_valid1; od = out_data1;
    end
  endtask

  // Entered and left at a negedge with the selected instance idle.
  task automatic run_word(input int div, input logic [N-1:0] data, input logic dir,
                          input logic [N-1:0] wire_bits, input int stall,
                          input logic keep_valid, input string tag);
    logic ir, so, ss, bz, ov;
    logic [N-1:0] od, exp_od;
    logic exp_ss;
    int idx;
    exp_od = rx_word(wire_bits, dir);
    in_valid = 1'b1; in_data = data; in_dir = dir; out_ready = 1'b0;
    sample(div, ir, so, ss, bz, ov, od);
    checks++;
    if (ir !== 1'b1 || bz !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: in_ready=%b busy=%b out_valid=%b, want 1 0 0", tag, ir, bz, ov);
    end
    @(posedge clock); @(negedge clock);
    if (!keep_valid) in_valid = 1'b0;
    in_data = N'($urandom);
    in_dir = 1'($urandom);
    for (int c = 1; c <= N * div; c++) begin
      sample(div, ir, so, ss, bz, ov, od);
      exp_ss = ((c % div) == 0);
      idx = (c - 1) / div;
      checks++;
      if (ss !== exp_ss || bz !== 1'b1 || ir !== 1'b0 || ov !== 1'b0) begin
        errors++;
        $display("FAIL %s ctl cyc %0d: strobe=%b busy=%b in_ready=%b out_valid=%b, want strobe=%b busy=1 in_ready=0 out_valid=0",
                 tag, c, ss, bz, ir, ov, exp_ss);
      end
      checks++;
      if (so !== tx_bit(data, dir, idx)) begin
        errors++;
        $display("FAIL %s ser_out cyc %0d: got %b want %b", tag, c, so, tx_bit(data, dir, idx));
      end
      ser_in = exp_ss ? wire_bits[idx] : 1'($urandom);
      @(posedge clock); @(negedge clock);
    end
    for (int s = 0; s <= stall; s++) begin
      in_valid = (s < stall) ? 1'b1 : keep_valid;
      out_ready = (s == stall);
      ser_in = 1'($urandom);
      sample(div, ir, so, ss, bz, ov, od);
      checks++;
      if (ov !== 1'b1 || od !== exp_od) begin
        errors++;
        $display("FAIL %s result cyc %0d: out_valid=%b out_data=%h, want 1 %h", tag, N*div+1+s, ov, od, exp_od);
      end
      checks++;
      if (ir !== 1'b0 || bz !== 1'b1 || ss !== 1'b0 || so !== 1'b0) begin
        errors++;
        $display("FAIL %s done ctl: in_ready=%b busy=%b strobe=%b ser_out=%b, want 0 1 0 0", tag, ir, bz, ss, so);
      end
      @(posedge clock); @(negedge clock);
    end
    sample(div, ir, so, ss, bz, ov, od);
    checks++;
    if (ir !== 1'b1 || bz !== 1'b0 || ov !== 1'b0 || so !== 1'b0 || ss !== 1'b0) begin
      errors++;
      $display("FAIL %s idle after handshake: in_ready=%b busy=%b out_valid=%b ser_out=%b strobe=%b, want 1 0 0 0 0",
               tag, ir, bz, ov, so, ss);
    end
  endtask

  task automatic do_reset();
    logic ir, so, ss, bz, ov;
    logic [N-1:0] od;
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ser_in = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int d = 1; d <= 3; d += 2) begin
      sample(d, ir, so, ss, bz, ov, od);
      checks++;
      if (ir !== 1'b1 || bz !== 1'b0 || ov !== 1'b0 || so !== 1'b0 || ss !== 1'b0 || od !== '0) begin
        errors++;
        $display("FAIL reset div%0d: in_ready=%b busy=%b out_valid=%b ser_out=%b strobe=%b out_data=%h, want 1 0 0 0 0 00",
                 d, ir, bz, ov, so, ss, od);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_msb_first();
    do_reset();
    run_word(1, 8'hA5, 1'b0, 8'b1000_0001, 0, 1'b0, "msb_A5");
    for (int i = 0; i < 3; i++)
      run_word(1, N'($urandom), 1'b0, N'($urandom), 0, 1'b0, "msb_rand");
  endtask

  task automatic test_lsb_first();
    do_reset();
    run_word(1, 8'hC1, 1'b1, 8'hFF, 0, 1'b0, "lsb_C1");
    for (int i = 0; i < 3; i++)
      run_word(1, N'($urandom), 1'b1, N'($urandom), 0, 1'b0, "lsb_rand");
  endtask

  task automatic test_clk_div();
    do_reset();
    run_word(3, 8'h0F, 1'b0, N'($urandom), 0, 1'b0, "div3_0F");
    run_word(3, N'($urandom), 1'b1, N'($urandom), 2, 1'b0, "div3_rand");
  endtask

  task automatic test_backpressure();
    do_reset();
    run_word(1, N'($urandom), 1'($urandom), N'($urandom), 5, 1'b0, "backpressure");
  endtask

  task automatic test_reset_mid_word();
    logic ir, so, ss, bz, ov;
    logic [N-1:0] od;
    do_reset();
    in_valid = 1'b1; in_data = 8'h3C; in_dir = 1'b0;
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      ser_in = 1'b1;
      @(posedge clock); @(negedge clock);
    end
    reset = 1'b1;
    #1;
    sample(1, ir, so, ss, bz, ov, od);
    checks++;
    if (ir !== 1'b1 || bz !== 1'b0 || ov !== 1'b0 || so !== 1'b0 || od !== '0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b busy=%b out_valid=%b ser_out=%b out_data=%h, want 1 0 0 0 00",
               ir, bz, ov, so, od);
    end
    @(negedge clock);
    reset = 1'b0;
    run_word(1, N'($urandom), 1'($urandom), N'($urandom), 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_word(1, N'($urandom), 1'b0, N'($urandom), 0, 1'b1, "b2b_1");
    run_word(1, N'($urandom), 1'b1, N'($urandom), 0, 1'b1, "b2b_2");
    run_word(1, N'($urandom), 1'($urandom), N'($urandom), 0, 1'b0, "b2b_3");
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_clk_div();
    test_backpressure();
    test_reset_mid_word();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
